// File: rtl/sram_cache_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : sram_cache_controller
//  Description : 2-way set-associative, write-through, no-write-allocate
//                read cache between the MEM pipeline stage and the SRAM
//                controller. One 32-bit word per line, one LRU bit per set.
//                Read hits return data combinationally. Read misses and all
//                writes go through the SRAM rd_en/wr_en/ready handshake,
//                and the pipeline is frozen through ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_cache_controller #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_write_data,
    input  logic [31:0] sram_read_data,
    input  logic        sram_ready
);

    localparam int c_NUM_SETS = 1 << INDEX_W;
    localparam int c_IDX_LSB  = 2;
    localparam int c_IDX_MSB  = c_IDX_LSB + INDEX_W - 1;
    localparam int c_TAG_LSB  = c_IDX_MSB + 1;
    localparam int c_TAG_MSB  = c_TAG_LSB + TAG_W - 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_READ_MISS = 2'd1,
        S_WRITE     = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Per-set bookkeeping: valid bits and LRU bit are resettable vectors,
    // tag/data storage is plain RAM that is qualified by the valid bits.
    logic [c_NUM_SETS-1:0] r_valid0;
    logic [c_NUM_SETS-1:0] r_valid1;
    logic [c_NUM_SETS-1:0] r_lru;
    logic [TAG_W-1:0]      r_tag0  [c_NUM_SETS];
    logic [TAG_W-1:0]      r_tag1  [c_NUM_SETS];
    logic [31:0]           r_data0 [c_NUM_SETS];
    logic [31:0]           r_data1 [c_NUM_SETS];

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit0;
    logic               w_hit1;
    logic               w_hit;
    logic               w_hit_way;
    logic [31:0]        w_hit_data;
    logic               w_victim;
    logic               w_way_sel;
    logic               w_fill;
    logic               w_wr_hit;
    logic               w_upd_lru;
    logic               w_we0;
    logic               w_we1;
    logic [31:0]        w_wdata;

    assign w_index = address[c_IDX_MSB:c_IDX_LSB];
    assign w_tag   = address[c_TAG_MSB:c_TAG_LSB];

    // Tag compare for both ways; way0 wins should both ever match.
    always_comb begin
        w_hit0     = r_valid0[w_index] && (r_tag0[w_index] == w_tag);
        w_hit1     = r_valid1[w_index] && (r_tag1[w_index] == w_tag);
        w_hit      = w_hit0 || w_hit1;
        w_hit_way  = !w_hit0;
        w_hit_data = w_hit0 ? r_data0[w_index] : r_data1[w_index];
    end

    // Victim choice: first invalid way (way0 first), otherwise the LRU way.
    always_comb begin
        if (!r_valid0[w_index]) begin
            w_victim = 1'b0;
        end else if (!r_valid1[w_index]) begin
            w_victim = 1'b1;
        end else begin
            w_victim = r_lru[w_index];
        end
    end

    // Next-state and handshake outputs; new requests are only sampled in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b1;
        read_data   = 32'h0;
        sram_rd_en  = 1'b0;
        sram_wr_en  = 1'b0;
        w_fill      = 1'b0;
        w_wr_hit    = 1'b0;
        w_upd_lru   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wr_en) begin
                    // Writes take priority over a simultaneous read.
                    ready       = 1'b0;
                    w_state_nxt = S_WRITE;
                    w_wr_hit    = w_hit;
                    w_upd_lru   = w_hit;
                end else if (rd_en) begin
                    if (w_hit) begin
                        read_data = w_hit_data;
                        w_upd_lru = 1'b1;
                    end else begin
                        ready       = 1'b0;
                        w_state_nxt = S_READ_MISS;
                    end
                end
            end
            S_READ_MISS: begin
                sram_rd_en = 1'b1;
                ready      = sram_ready;
                if (sram_ready) begin
                    read_data   = sram_read_data;
                    w_fill      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                sram_wr_en = 1'b1;
                ready      = sram_ready;
                if (sram_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // SRAM-side address/data are only driven while an access is outstanding.
    always_comb begin
        sram_address    = (r_state != S_IDLE) ? address : 32'h0;
        sram_write_data = sram_wr_en ? write_data : 32'h0;
    end

    // Way selection and write enables for the storage arrays.
    always_comb begin
        w_way_sel = w_fill ? w_victim : w_hit_way;
        w_we0     = (w_fill && !w_victim) || (w_wr_hit && !w_hit_way);
        w_we1     = (w_fill &&  w_victim) || (w_wr_hit &&  w_hit_way);
        w_wdata   = w_fill ? sram_read_data : write_data;
    end

    // State register; reset aborts any outstanding SRAM access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Valid and LRU bits: set on fill, LRU points away from the way just used.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid0 <= '0;
            r_valid1 <= '0;
            r_lru    <= '0;
        end else begin
            if (w_fill) begin
                if (w_victim) begin
                    r_valid1[w_index] <= 1'b1;
                end else begin
                    r_valid0[w_index] <= 1'b1;
                end
            end
            if (w_fill || w_upd_lru) begin
                r_lru[w_index] <= ~w_way_sel;
            end
        end
    end

    // Tag/data storage: fills write tag and data, write hits update data only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_we0) begin
                r_data0[w_index] <= w_wdata;
            end
            if (w_we1) begin
                r_data1[w_index] <= w_wdata;
            end
            if (w_fill && !w_victim) begin
                r_tag0[w_index] <= w_tag;
            end
            if (w_fill && w_victim) begin
                r_tag1[w_index] <= w_tag;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_cache_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_sram_cache_controller
//  Description : Self-checking bench for sram_cache_controller with an SRAM
//                responder and a transaction-level cache reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_cache_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_address;
    logic [31:0] sram_write_data;
    logic [31:0] sram_read_data;
    logic        sram_ready;

    int n_checks = 0;
    int n_errors = 0;

    sram_cache_controller #(.INDEX_W(6), .TAG_W(11)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .rd_en           (rd_en),
        .wr_en           (wr_en),
        .address         (address),
        .write_data      (write_data),
        .read_data       (read_data),
        .ready           (ready),
        .sram_rd_en      (sram_rd_en),
        .sram_wr_en      (sram_wr_en),
        .sram_address    (sram_address),
        .sram_write_data (sram_write_data),
        .sram_read_data  (sram_read_data),
        .sram_ready      (sram_ready)
    );

    always #5 clk = ~clk;

    // SRAM responder: ready in the lat-th enabled cycle, high whenever idle.
    logic [31:0] sram_mem [131072];
    int          sram_cnt = 0;
    int          sram_lat = 1;

    assign sram_ready     = (sram_rd_en || sram_wr_en) ? (sram_cnt == sram_lat - 1) : 1'b1;
    assign sram_read_data = sram_rd_en ? sram_mem[sram_address[18:2]] : 32'h0;

    always @(posedge clk) begin
        if (sram_wr_en && sram_ready) sram_mem[sram_address[18:2]] = sram_write_data;
        if (sram_rd_en || sram_wr_en) sram_cnt <= sram_cnt + 1;
        else                          sram_cnt <= 0;
    end

    // Reference model: memory contents and cache state from the cache rules.
    logic [31:0] ref_mem [131072];
    logic        m_valid [64][2];
    logic [10:0] m_tag   [64][2];
    logic [31:0] m_data  [64][2];
    logic        m_lru   [64];

    function automatic int m_lookup(input logic [31:0] a);
        int s;
        s = int'(a[7:2]);
        if (m_valid[s][0] && m_tag[s][0] == a[18:8]) return 0;
        if (m_valid[s][1] && m_tag[s][1] == a[18:8]) return 1;
        return -1;
    endfunction

    task automatic m_reset();
        for (int s = 0; s < 64; s++) begin
            m_valid[s][0] = 1'b0;
            m_valid[s][1] = 1'b0;
            m_lru[s]      = 1'b0;
        end
    endtask

    task automatic m_fill(input logic [31:0] a, input logic [31:0] d);
        int s;
        int v;
        s = int'(a[7:2]);
        if (!m_valid[s][0])      v = 0;
        else if (!m_valid[s][1]) v = 1;
        else                     v = m_lru[s] ? 1 : 0;
        m_valid[s][v] = 1'b1;
        m_tag[s][v]   = a[18:8];
        m_data[s][v]  = d;
        m_lru[s]      = (v == 0);
    endtask

    // Expected outputs for the current cycle, published by the driver.
    logic        chk_en = 1'b0;
    logic        e_ready, e_srd, e_swr, e_rchk;
    logic [31:0] e_rdata, e_saddr, e_swd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_exp(input logic r, input logic srd, input logic swr, input logic rc,
                           input logic [31:0] rd, input logic [31:0] sa, input logic [31:0] swd);
        e_ready = r; e_srd = srd; e_swr = swr; e_rchk = rc;
        e_rdata = rd; e_saddr = sa; e_swd = swd;
    endtask

    // Single compare process, sampling mid-cycle away from the clock edge.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("ready", {31'h0, ready}, {31'h0, e_ready});
            chk("sram_rd_en", {31'h0, sram_rd_en}, {31'h0, e_srd});
            chk("sram_wr_en", {31'h0, sram_wr_en}, {31'h0, e_swr});
            chk("sram_address", sram_address, e_saddr);
            chk("sram_write_data", sram_write_data, e_swd);
            if (e_rchk) chk("read_data", read_data, e_rdata);
        end
    end

    task automatic idle_cycle();
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        address = $urandom; write_data = $urandom;
        set_exp(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    endtask

    // One pipeline request, cycle by cycle, with the model's expectations.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input int lat, input int exp_hit,
                          output logic [31:0] obs);
        int          way;
        int          s;
        logic [16:0] wa;
        way = m_lookup(a);
        s   = int'(a[7:2]);
        wa  = a[18:2];
        obs = 32'h0;
        if (exp_hit >= 0) chk("model_hit", (way >= 0) ? 32'h1 : 32'h0, (exp_hit != 0) ? 32'h1 : 32'h0);
        sram_lat = lat;
        @(negedge clk);
        rd_en = rd; wr_en = wr; address = a; write_data = wd;
        if (wr) begin
            set_exp(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                set_exp(k == lat, 1'b0, 1'b1, 1'b0, 32'h0, a, wd);
            end
            if (way >= 0) begin
                m_data[s][way] = wd;
                m_lru[s]       = (way == 0);
            end
            ref_mem[wa] = wd;
            idle_cycle();
        end else if (rd) begin
            if (way >= 0) begin
                set_exp(1'b1, 1'b0, 1'b0, 1'b1, m_data[s][way], 32'h0, 32'h0);
                m_lru[s] = (way == 0);
                #1 obs = read_data;
            end else begin
                set_exp(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
                for (int k = 1; k <= lat; k++) begin
                    @(negedge clk);
                    set_exp(k == lat, 1'b1, 1'b0, k == lat, (k == lat) ? ref_mem[wa] : 32'h0, a, 32'h0);
                end
                #1 obs = read_data;
                m_fill(a, ref_mem[wa]);
                idle_cycle();
            end
        end else begin
            set_exp(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] obs;
        logic [31:0] a;
        int          op;
        for (int i = 0; i < 131072; i++) begin
            sram_mem[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
            ref_mem[i]  = sram_mem[i];
        end
        sram_mem[17'h104] = 32'hDEADBEEF;
        ref_mem[17'h104]  = 32'hDEADBEEF;
        m_reset();

        // Reset, then check idle outputs.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        chk_en = 1'b1;
        idle_cycle();

        // Cold read, then hit.
        do_req(1'b1, 1'b0, 32'h0000_0410, 32'h0, 6, 0, obs);
        chk("cold_read_data", obs, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 32'h0000_0410, 32'h0, 6, 1, obs);
        chk("hit_read_data", obs, 32'hDEADBEEF);

        // Write hit, read back from cache.
        do_req(1'b0, 1'b1, 32'h0000_0410, 32'h12345678, 4, 1, obs);
        do_req(1'b1, 1'b0, 32'h0000_0410, 32'h0, 4, 1, obs);
        chk("write_hit_readback", obs, 32'h12345678);

        // Write miss does not allocate.
        do_req(1'b0, 1'b1, 32'h0000_0820, 32'hCAFEF00D, 3, 0, obs);
        do_req(1'b1, 1'b0, 32'h0000_0820, 32'h0, 3, 0, obs);
        chk("write_miss_readback", obs, 32'hCAFEF00D);

        // LRU in set 0.
        do_req(1'b1, 1'b0, 32'h0000_0000, 32'h0, 2, 0, obs);
        do_req(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2, 0, obs);
        do_req(1'b1, 1'b0, 32'h0000_0000, 32'h0, 2, 1, obs);
        do_req(1'b1, 1'b0, 32'h0000_0200, 32'h0, 2, 0, obs);
        do_req(1'b1, 1'b0, 32'h0000_0000, 32'h0, 2, 1, obs);
        do_req(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2, 0, obs);

        // Reset during READ_MISS.
        sram_lat = 6;
        @(negedge clk);
        rd_en = 1'b1; wr_en = 1'b0; address = 32'h0000_0C44;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            set_exp(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0C44, 32'h0);
        end
        @(negedge clk);
        rst = 1'b1; chk_en = 1'b0;
        @(negedge clk);
        rst = 1'b0; rd_en = 1'b0; chk_en = 1'b1;
        set_exp(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        m_reset();
        do_req(1'b1, 1'b0, 32'h0000_0000, 32'h0, 2, 0, obs);
        do_req(1'b1, 1'b0, 32'h0000_0410, 32'h0, 2, 0, obs);
        chk("post_reset_refetch", obs, 32'h12345678);

        // Simultaneous read and write is a write.
        do_req(1'b1, 1'b1, 32'h0000_0430, 32'hA5A50430, 3, 0, obs);
        do_req(1'b1, 1'b0, 32'h0000_0430, 32'h0, 3, 0, obs);
        chk("rdwr_readback", obs, 32'hA5A50430);

        // Randomized traffic over a few sets/tags to force hits and evictions.
        for (int n = 0; n < 400; n++) begin
            a        = $urandom;
            a[7:2]   = 6'($urandom_range(0, 3));
            a[18:8]  = 11'($urandom_range(0, 3));
            op       = $urandom_range(0, 99);
            if (op < 40)      do_req(1'b0, 1'b1, a, $urandom, $urandom_range(1, 5), -1, obs);
            else if (op < 90) do_req(1'b1, 1'b0, a, $urandom, $urandom_range(1, 5), -1, obs);
            else if (op < 95) do_req(1'b1, 1'b1, a, $urandom, $urandom_range(1, 5), -1, obs);
            else              do_req(1'b0, 1'b0, a, $urandom, 1, -1, obs);
        end

        idle_cycle();
        @(negedge clk);
        #4;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
